// File: rtl/nice_uid_pkg.sv
// Shared types and default sizing for the nice UID allocator.
// Optional overflow tracking is enabled with NICE_UID_OVERFLOW_CHECK_EN.
package nice_uid_pkg;

    localparam int unsigned NumReqDef   = 4;
    localparam int unsigned NumClassDef = 8;
    localparam int unsigned UidWDef     = 16;

    typedef enum logic {
        RSP_EMPTY,
        RSP_FULL
    } rsp_state_e;

    // Response slot layout for the default configuration.
    typedef struct packed {
        logic [$clog2(NumReqDef)-1:0]   req;
        logic [$clog2(NumClassDef)-1:0] cls;
        logic [UidWDef-1:0]             uid;
    } rsp_t;

endpackage

// File: rtl/nice_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer, with wrap.
// The pointer moves past the winner whenever a grant is issued with advance_i high.
module nice_rr_arbiter
    import nice_uid_pkg::*;
#(
    parameter int unsigned N = NumReqDef
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] req_i,
    input  logic         en_i,
    input  logic         advance_i,
    output logic [N-1:0] gnt_o
);

    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

    logic [IdxW-1:0] ptr_q, ptr_d;

    always_comb begin
        logic            found;
        logic [IdxW-1:0] idx;
        gnt_o = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = '0;
        if (en_i) begin
            for (int unsigned k = 0; k < N; k++) begin
                idx = IdxW'((32'(ptr_q) + k) % N);
                if (!found && req_i[idx]) begin
                    found      = 1'b1;
                    gnt_o[idx] = 1'b1;
                    if (advance_i) begin
                        ptr_d = IdxW'((32'(idx) + 1) % N);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/nice_uid_alloc.sv
// Per-class UID allocator shared by NUM_REQ requesters through one registered response slot.
// Define NICE_UID_OVERFLOW_CHECK_EN to make exhausted classes stick and expose err_overflow_o.
module nice_uid_alloc
    import nice_uid_pkg::*;
#(
    parameter int unsigned NUM_REQ   = NumReqDef,
    parameter int unsigned NUM_CLASS = NumClassDef,
    parameter int unsigned UID_W     = UidWDef,
    localparam int unsigned CLS_W    = $clog2(NUM_CLASS),
    localparam int unsigned REQ_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ*CLS_W-1:0] req_class_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [REQ_W-1:0]         rsp_req_o,
    output logic [CLS_W-1:0]         rsp_class_o,
    output logic [UID_W-1:0]         rsp_uid_o,
    input  logic                     clr_valid_i,
    input  logic [CLS_W-1:0]         clr_class_i
`ifdef NICE_UID_OVERFLOW_CHECK_EN
    ,
    output logic                     err_overflow_o
`endif
);

    typedef struct packed {
        logic [REQ_W-1:0] req;
        logic [CLS_W-1:0] cls;
        logic [UID_W-1:0] uid;
    } slot_t;

    rsp_state_e        state_q;
    slot_t             slot_q;
    logic [UID_W-1:0]  cnt_q [NUM_CLASS];
    logic [UID_W-1:0]  cnt_d [NUM_CLASS];

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] gnt;
    logic               avail;
    logic               grant;
    logic [REQ_W-1:0]   win_idx;
    logic [CLS_W-1:0]   win_cls;
    logic [UID_W-1:0]   grant_uid;

`ifdef NICE_UID_OVERFLOW_CHECK_EN
    logic [NUM_CLASS-1:0] exh_q, exh_d;
    logic                 err_q, err_d;
`endif

    assign avail = (state_q == RSP_EMPTY) || rsp_ready_i;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid_i[i];
`ifdef NICE_UID_OVERFLOW_CHECK_EN
            // Exhausted classes are masked so the arbiter serves someone else.
            if (exh_q[req_class_i[i*CLS_W +: CLS_W]]) begin
                eligible[i] = 1'b0;
            end
`endif
        end
    end

    nice_rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (eligible),
        .en_i      (avail && !rst_i),
        .advance_i (avail),
        .gnt_o     (gnt)
    );

    assign req_ready_o = gnt;
    assign grant       = |gnt;

    always_comb begin
        win_idx = '0;
        win_cls = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                win_idx = REQ_W'(i);
                win_cls = req_class_i[i*CLS_W +: CLS_W];
            end
        end
    end

    // A same-cycle clear of the granted class wins over the stored count.
    assign grant_uid = (clr_valid_i && (clr_class_i == win_cls)) ? '0 : cnt_q[win_cls];

    always_comb begin
        cnt_d = cnt_q;
        if (clr_valid_i) begin
            cnt_d[clr_class_i] = '0;
        end
        if (grant) begin
            cnt_d[win_cls] = grant_uid + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_CLASS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifdef NICE_UID_OVERFLOW_CHECK_EN
    always_comb begin
        exh_d = exh_q;
        err_d = err_q;
        if (clr_valid_i) begin
            exh_d[clr_class_i] = 1'b0;
        end
        if (grant && (grant_uid == '1)) begin
            exh_d[win_cls] = 1'b1;
            err_d          = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            exh_q <= '0;
            err_q <= 1'b0;
        end else begin
            exh_q <= exh_d;
            err_q <= err_d;
        end
    end

    assign err_overflow_o = err_q;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RSP_EMPTY;
            slot_q  <= '0;
        end else begin
            unique case (state_q)
                RSP_EMPTY: begin
                    if (grant) begin
                        state_q <= RSP_FULL;
                        slot_q  <= '{req: win_idx, cls: win_cls, uid: grant_uid};
                    end
                end
                RSP_FULL: begin
                    if (grant) begin
                        slot_q <= '{req: win_idx, cls: win_cls, uid: grant_uid};
                    end else if (rsp_ready_i) begin
                        state_q <= RSP_EMPTY;
                    end
                end
                default: state_q <= RSP_EMPTY;
            endcase
        end
    end

    assign rsp_valid_o = (state_q == RSP_FULL);
    assign rsp_req_o   = slot_q.req;
    assign rsp_class_o = slot_q.cls;
    assign rsp_uid_o   = slot_q.uid;

endmodule

// File: tb/tb_nice_uid_alloc.sv
// Self-checking bench for nice_uid_alloc with a narrow UID so counter wrap is reachable.
// Honours NICE_UID_OVERFLOW_CHECK_EN in the same way as the design.
module tb_nice_uid_alloc;

    localparam int NR   = 4;
    localparam int NC   = 8;
    localparam int UW   = 4;
    localparam int CW   = 3;
    localparam int RW   = 2;
    localparam int MAXU = (1 << UW) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR*CW-1:0] req_class;
    logic [NR-1:0]    req_ready;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [RW-1:0]    rsp_req;
    logic [CW-1:0]    rsp_class;
    logic [UW-1:0]    rsp_uid;
    logic             clr_valid;
    logic [CW-1:0]    clr_class;
`ifdef NICE_UID_OVERFLOW_CHECK_EN
    logic             err_overflow;
`endif

    nice_uid_alloc #(
        .NUM_REQ   (NR),
        .NUM_CLASS (NC),
        .UID_W     (UW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_class_i    (req_class),
        .req_ready_o    (req_ready),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .rsp_req_o      (rsp_req),
        .rsp_class_o    (rsp_class),
        .rsp_uid_o      (rsp_uid),
`ifdef NICE_UID_OVERFLOW_CHECK_EN
        .err_overflow_o (err_overflow),
`endif
        .clr_valid_i    (clr_valid),
        .clr_class_i    (clr_class)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_cnt [NC];
    bit m_exh [NC];
    int m_ptr;
    bit m_full;
    int m_req, m_cls, m_uid;
    bit m_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NC; i++) begin
            m_cnt[i] = 0;
            m_exh[i] = 1'b0;
        end
        m_ptr  = 0;
        m_full = 1'b0;
        m_req  = 0;
        m_cls  = 0;
        m_uid  = 0;
        m_err  = 1'b0;
    endfunction

    function automatic int cls_of(int i);
        return int'(req_class[i*CW +: CW]);
    endfunction

    function automatic bit blocked(int c);
`ifdef NICE_UID_OVERFLOW_CHECK_EN
        return m_exh[c];
`else
        return 1'b0 && (c < 0);
`endif
    endfunction

    // Index of the requester the model expects to win, or -1.
    function automatic int model_winner();
        if (m_full && !rsp_ready) return -1;
        for (int k = 0; k < NR; k++) begin
            int i;
            i = (m_ptr + k) % NR;
            if (req_valid[i] && !blocked(cls_of(i))) return i;
        end
        return -1;
    endfunction

    // Called right after a negedge with inputs already set; returns at the next negedge.
    task automatic step(output int w);
        int c;
        int uid;
        logic [NR-1:0] exp_rdy;
        #1;
        w       = model_winner();
        exp_rdy = (w >= 0) ? NR'(1 << w) : '0;
        check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
        c = (w >= 0) ? cls_of(w) : 0;
        @(posedge clk);
        if (clr_valid) begin
            m_cnt[clr_class] = 0;
            m_exh[clr_class] = 1'b0;
        end
        if (w >= 0) begin
            uid      = m_cnt[c];
            m_full   = 1'b1;
            m_req    = w;
            m_cls    = c;
            m_uid    = uid;
            m_cnt[c] = (uid + 1) % (1 << UW);
            if (uid == MAXU) begin
                m_exh[c] = 1'b1;
                m_err    = 1'b1;
            end
            m_ptr = (w + 1) % NR;
        end else if (m_full && rsp_ready) begin
            m_full = 1'b0;
        end
        @(negedge clk);
        check_eq("rsp_valid", 32'(rsp_valid), 32'(m_full));
        if (m_full) begin
            check_eq("rsp_req", 32'(rsp_req), 32'(m_req));
            check_eq("rsp_class", 32'(rsp_class), 32'(m_cls));
            check_eq("rsp_uid", 32'(rsp_uid), 32'(m_uid));
        end
`ifdef NICE_UID_OVERFLOW_CHECK_EN
        check_eq("err_overflow", 32'(err_overflow), 32'(m_err));
`endif
    endtask

    // Called at a negedge; asserts reset mid-cycle and checks the immediate effect.
    task automatic reset_dut();
        #2 rst = 1'b1;
        #1;
        check_eq("rst_rsp_valid", 32'(rsp_valid), 0);
        check_eq("rst_req_ready", 32'(req_ready), 0);
        check_eq("rst_rsp_req", 32'(rsp_req), 0);
        check_eq("rst_rsp_class", 32'(rsp_class), 0);
        check_eq("rst_rsp_uid", 32'(rsp_uid), 0);
`ifdef NICE_UID_OVERFLOW_CHECK_EN
        check_eq("rst_err", 32'(err_overflow), 0);
`endif
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_class(input int i, input int c);
        req_class[i*CW +: CW] = CW'(c);
    endtask

    initial begin
        int w;
        rst       = 1'b1;
        req_valid = '1;
        req_class = '0;
        rsp_ready = 1'b1;
        clr_valid = 1'b0;
        clr_class = '0;
        model_reset();
        @(negedge clk);
        check_eq("init_req_ready", 32'(req_ready), 0);
        check_eq("init_rsp_valid", 32'(rsp_valid), 0);
        req_valid = '0;
        rst       = 1'b0;

        // Single request, then the same request again
        set_class(2, 3);
        req_valid = 4'b0100;
        step(w);
        check_eq("t1_req", 32'(rsp_req), 2);
        check_eq("t1_uid0", 32'(rsp_uid), 0);
        step(w);
        check_eq("t1_uid1", 32'(rsp_uid), 1);

        // All requesters on class 0 from reset: round-robin, one per cycle
        req_valid = '0;
        reset_dut();
        for (int i = 0; i < NR; i++) set_class(i, 0);
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            step(w);
            check_eq("rr_order", 32'(rsp_req), 32'(k % NR));
            check_eq("rr_uid", 32'(rsp_uid), 32'(k));
        end

        // Backpressure holds the slot, then drains and reloads in one cycle
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) step(w);
        rsp_ready = 1'b1;
        step(w);
        check_eq("bp_release_uid", 32'(rsp_uid), 8);

        // Clear class 5 while granting it
        set_class(1, 5);
        req_valid = 4'b0010;
        for (int k = 0; k < 7; k++) step(w);
        clr_valid = 1'b1;
        clr_class = 3'd5;
        step(w);
        check_eq("clr_uid0", 32'(rsp_uid), 0);
        clr_valid = 1'b0;
        step(w);
        check_eq("clr_uid1", 32'(rsp_uid), 1);

        // Counter exhaustion / wrap on class 0
        req_valid = '0;
        reset_dut();
        set_class(0, 0);
        set_class(1, 1);
        req_valid = 4'b0001;
        for (int k = 0; k < 16; k++) step(w);
        check_eq("ovf_last_uid", 32'(rsp_uid), 32'(MAXU));
        req_valid = 4'b0011;
        step(w);
        step(w);
`ifdef NICE_UID_OVERFLOW_CHECK_EN
        check_eq("ovf_other_served", 32'(rsp_req), 1);
        check_eq("ovf_err", 32'(err_overflow), 1);
`else
        check_eq("wrap_req", 32'(rsp_req), 0);
        check_eq("wrap_uid", 32'(rsp_uid), 0);
`endif

        // Asynchronous reset with a pending response
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        step(w);
        check_eq("ar_pending", 32'(rsp_valid), 1);
        req_valid = '0;
        reset_dut();
        set_class(1, 3);
        set_class(3, 3);
        req_valid = 4'b1010;
        rsp_ready = 1'b1;
        step(w);
        check_eq("ar_first_req", 32'(rsp_req), 1);
        check_eq("ar_first_uid", 32'(rsp_uid), 0);

        // Randomized traffic with held requests, backpressure and clears
        req_valid = '0;
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] && ($urandom_range(0, 2) == 0)) begin
                    set_class(i, $urandom_range(0, NC - 1));
                    req_valid[i] = 1'b1;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            clr_valid = ($urandom_range(0, 11) == 0);
            clr_class = CW'($urandom_range(0, NC - 1));
            step(w);
            if (w >= 0) req_valid[w] = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
